// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a loadable pattern, a per-bit care mask,
// selectable overlapping detection and a saturating match counter.
module seq_pattern_detector #(
  parameter int               PAT_W     = 4,
  parameter int               CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = 4'b1101
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  input  logic             clear,
  input  logic             a_valid,
  input  logic             a,
  output logic             smile,
  output logic             armed,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] mask_q, mask_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             smile_q, smile_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] nhist;
  logic [FW-1:0]    nfill;
  logic             hit;

  always_comb begin
    pat_d   = pat_q;
    mask_d  = mask_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    smile_d = 1'b0;
    cnt_d   = cnt_q;
    nhist   = {hist_q[PAT_W-2:0], a};
    nfill   = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    hit     = (nfill == FULL) &&
              (((nhist ^ pat_q) & mask_q) == '0);
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      mask_d = cfg_mask;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (clear) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (a_valid) begin
      hist_d  = nhist;
      smile_d = hit;
      // non-overlapping mode needs a full fresh window after a hit
      fill_d  = (hit && !ovl_q) ? '0 : nfill;
      if (hit && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pat_q   <= RESET_PAT;
      mask_q  <= '1;
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      smile_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      smile_q <= smile_d;
      cnt_q   <= cnt_d;
    end
  end

  assign smile       = smile_q;
  assign armed       = (fill_q == FULL);
  assign match_count = cnt_q;

endmodule
